// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall unit resolving Tuse/Tnew data hazards between ID and EX/MEM.
// Define HAZARD_MDU_STALL_EN to add the multiply/divide busy counter and its interlock.
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_E,
  input  logic [31:0] IR_M,
  output logic        PC_en,
  output logic        IF_ID_en,
  output logic        ID_EX_reset,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

`ifdef HAZARD_MDU_STALL_EN
  localparam logic MDU_EN = 1'b1;
`else
  localparam logic MDU_EN = 1'b0;
`endif

  // Tuse of an operand that is not read; compares as never-less-than any Tnew.
  localparam logic [1:0] T_NONE = 2'd3;

  typedef struct packed {
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic [4:0] dst;
    logic [1:0] tnew_e;
    logic [1:0] tnew_m;
    logic       md_class;
    logic       md_start;
    logic [3:0] md_lat;
  } dec_t;

  localparam dec_t DEC_NONE = '{tuse_rs: T_NONE, tuse_rt: T_NONE, dst: 5'd0,
                                tnew_e: 2'd0, tnew_m: 2'd0, md_class: 1'b0,
                                md_start: 1'b0, md_lat: 4'd0};

  function automatic dec_t decode(input logic [31:0] ir);
    dec_t d;
    d = DEC_NONE;
    case (ir[31:26])
      6'h00: begin
        case (ir[5:0])
          6'h21, 6'h23: begin
            d.tuse_rs = 2'd1; d.tuse_rt = 2'd1; d.dst = ir[15:11]; d.tnew_e = 2'd1;
          end
          6'h08: d.tuse_rs = 2'd0;
          6'h18, 6'h19: begin
            d.tuse_rs = 2'd1; d.tuse_rt = 2'd1; d.md_class = 1'b1;
            d.md_start = 1'b1; d.md_lat = 4'd5;
          end
          6'h1A, 6'h1B: begin
            d.tuse_rs = 2'd1; d.tuse_rt = 2'd1; d.md_class = 1'b1;
            d.md_start = 1'b1; d.md_lat = 4'd10;
          end
          6'h10, 6'h12: begin
            d.dst = ir[15:11]; d.tnew_e = 2'd1; d.md_class = 1'b1;
          end
          6'h11, 6'h13: begin
            d.tuse_rs = 2'd1; d.md_class = 1'b1;
          end
          default: d = DEC_NONE;
        endcase
      end
      6'h0D: begin d.tuse_rs = 2'd1; d.dst = ir[20:16]; d.tnew_e = 2'd1; end
      6'h0F: begin d.dst = ir[20:16]; d.tnew_e = 2'd1; end
      6'h23: begin
        d.tuse_rs = 2'd1; d.dst = ir[20:16]; d.tnew_e = 2'd2; d.tnew_m = 2'd1;
      end
      6'h2B: begin d.tuse_rs = 2'd1; d.tuse_rt = 2'd2; end
      6'h04: begin d.tuse_rs = 2'd0; d.tuse_rt = 2'd0; end
      6'h03: d.dst = 5'd31;
      default: d = DEC_NONE;
    endcase
    // Without the MDU interlock these opcodes carry no hazard information at all.
    decode = (d.md_class && !MDU_EN) ? DEC_NONE : d;
  endfunction

  function automatic logic hit(input logic [4:0] src, input logic [1:0] tuse,
                               input logic [4:0] dst, input logic [1:0] tnew);
    hit = (tuse != T_NONE) && (src != 5'd0) && (src == dst) && (tuse < tnew);
  endfunction

  dec_t dec_d_s, dec_e_s, dec_m_s;
  logic data_stall_s, md_stall_s, stall_s;
  logic [31:0] stall_cnt_q;

  assign dec_d_s = decode(IR_D);
  assign dec_e_s = decode(IR_E);
  assign dec_m_s = decode(IR_M);

  assign data_stall_s = hit(IR_D[25:21], dec_d_s.tuse_rs, dec_e_s.dst, dec_e_s.tnew_e)
                      | hit(IR_D[20:16], dec_d_s.tuse_rt, dec_e_s.dst, dec_e_s.tnew_e)
                      | hit(IR_D[25:21], dec_d_s.tuse_rs, dec_m_s.dst, dec_m_s.tnew_m)
                      | hit(IR_D[20:16], dec_d_s.tuse_rt, dec_m_s.dst, dec_m_s.tnew_m);

`ifdef HAZARD_MDU_STALL_EN
  logic [3:0] md_cnt_q, md_cnt_d;

  // A new start always reloads the counter, even mid-operation.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (dec_e_s.md_start) begin
      md_cnt_d = dec_e_s.md_lat;
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end else begin
      md_cnt_d = 4'd0;
    end
  end

  // MDU remaining-cycles counter
  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q <= 4'd0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign md_busy = dec_e_s.md_start | (md_cnt_q != 4'd0);
`else
  assign md_busy = 1'b0;
`endif

  assign md_stall_s  = md_busy & dec_d_s.md_class;
  assign stall_s     = data_stall_s | md_stall_s;
  assign PC_en       = ~stall_s;
  assign IF_ID_en    = ~stall_s;
  assign ID_EX_reset = stall_s;
  assign stall_cnt   = stall_cnt_q;

  // Stalled-cycle counter, wraps naturally at 32 bits
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 32'd0;
    end else if (stall_s) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_q <= stall_cnt_q;
    end
  end

  logic unused_s;
  assign unused_s = ^{IR_D[10:6], IR_E[10:6], IR_M[10:6], IR_E[25:21], IR_M[25:21],
                      dec_d_s.dst, dec_d_s.tnew_e, dec_d_s.tnew_m, dec_d_s.md_start,
                      dec_d_s.md_lat, dec_e_s.tuse_rs, dec_e_s.tuse_rt, dec_e_s.tnew_m,
                      dec_e_s.md_class, dec_e_s.md_start, dec_e_s.md_lat,
                      dec_m_s.tuse_rs, dec_m_s.tuse_rt, dec_m_s.tnew_e,
                      dec_m_s.md_class, dec_m_s.md_start, dec_m_s.md_lat};

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed hazard scenarios plus randomized instruction mixes checked
// against a table-driven reference model of the stall rules.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR_D, IR_E, IR_M;
  logic        PC_en, IF_ID_en, ID_EX_reset, md_busy;
  logic [31:0] stall_cnt;

`ifdef HAZARD_MDU_STALL_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif

  hazard_ctrl dut (
    .clk(clk), .reset(reset), .IR_D(IR_D), .IR_E(IR_E), .IR_M(IR_M),
    .PC_en(PC_en), .IF_ID_en(IF_ID_en), .ID_EX_reset(ID_EX_reset),
    .md_busy(md_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // reference state: cycle index, last busy cycle of the MDU, expected stall count
  int          cyc = 0;
  int          busy_end = -1;
  logic [31:0] cnt_ref = 32'd0;

  // kinds: 0 none, 1 addu, 2 subu, 3 ori, 4 lui, 5 lw, 6 sw, 7 beq, 8 j, 9 jal, 10 jr,
  //        11 mult, 12 multu, 13 div, 14 divu, 15 mfhi, 16 mflo, 17 mthi, 18 mtlo
  int tuse_rs_t[19] = '{-1, 1, 1, 1, -1, 1, 1, 0, -1, -1, 0, 1, 1, 1, 1, -1, -1, 1, 1};
  int tuse_rt_t[19] = '{-1, 1, 1, -1, -1, -1, 2, 0, -1, -1, -1, 1, 1, 1, 1, -1, -1, -1, -1};
  int tnew_e_t[19]  = '{0, 1, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
  int md_lat_t[19]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 5, 10, 10, 0, 0, 0, 0};

  function automatic int kind_of(logic [31:0] ir);
    int k;
    k = 0;
    if (ir[31:26] == 6'h00) begin
      case (ir[5:0])
        6'h21: k = 1;  6'h23: k = 2;  6'h08: k = 10; 6'h18: k = 11;
        6'h19: k = 12; 6'h1A: k = 13; 6'h1B: k = 14; 6'h10: k = 15;
        6'h12: k = 16; 6'h11: k = 17; 6'h13: k = 18; default: k = 0;
      endcase
    end else begin
      case (ir[31:26])
        6'h0D: k = 3; 6'h0F: k = 4; 6'h23: k = 5; 6'h2B: k = 6;
        6'h04: k = 7; 6'h02: k = 8; 6'h03: k = 9; default: k = 0;
      endcase
    end
    if (!MDU && k >= 11) k = 0;
    return k;
  endfunction

  function automatic int dest_of(logic [31:0] ir);
    int k;
    k = kind_of(ir);
    if (k == 1 || k == 2 || k == 15 || k == 16) return int'(ir[15:11]);
    if (k == 3 || k == 4 || k == 5) return int'(ir[20:16]);
    if (k == 9) return 31;
    return 0;
  endfunction

  function automatic bit conflict(int src, int tuse, int dst, int tnew);
    return (tuse >= 0) && (src != 0) && (src == dst) && (tuse < tnew);
  endfunction

  function automatic bit ref_data_stall();
    int kd, te, tm, rs, rt;
    kd = kind_of(IR_D);
    rs = int'(IR_D[25:21]);
    rt = int'(IR_D[20:16]);
    te = tnew_e_t[kind_of(IR_E)];
    tm = (kind_of(IR_M) == 5) ? 1 : 0;
    return conflict(rs, tuse_rs_t[kd], dest_of(IR_E), te) ||
           conflict(rt, tuse_rt_t[kd], dest_of(IR_E), te) ||
           conflict(rs, tuse_rs_t[kd], dest_of(IR_M), tm) ||
           conflict(rt, tuse_rt_t[kd], dest_of(IR_M), tm);
  endfunction

  function automatic logic [31:0] r_ins(int rs, int rt, int rd, logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(logic [5:0] op, int rs, int rt, logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  function automatic logic [31:0] enc(int k, int rs, int rt, int rd, logic [15:0] imm);
    case (k)
      1:  return r_ins(rs, rt, rd, 6'h21);
      2:  return r_ins(rs, rt, rd, 6'h23);
      3:  return i_ins(6'h0D, rs, rt, imm);
      4:  return i_ins(6'h0F, 0, rt, imm);
      5:  return i_ins(6'h23, rs, rt, imm);
      6:  return i_ins(6'h2B, rs, rt, imm);
      7:  return i_ins(6'h04, rs, rt, imm);
      8:  return {6'h02, 26'h10};
      9:  return {6'h03, 26'h10};
      10: return r_ins(rs, 0, 0, 6'h08);
      11: return r_ins(rs, rt, 0, 6'h18);
      12: return r_ins(rs, rt, 0, 6'h19);
      13: return r_ins(rs, rt, 0, 6'h1A);
      14: return r_ins(rs, rt, 0, 6'h1B);
      15: return r_ins(0, 0, rd, 6'h10);
      16: return r_ins(0, 0, rd, 6'h12);
      17: return r_ins(rs, 0, 0, 6'h11);
      18: return r_ins(rs, 0, 0, 6'h13);
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model at the edge.
  task automatic step(input string tag, input int exp_stall, input int exp_busy, input int exp_cnt);
    bit st, bz, start;
    int ke, kd;
    @(negedge clk);
    ke = kind_of(IR_E);
    kd = kind_of(IR_D);
    start = (md_lat_t[ke] != 0);
    bz = start || (cyc <= busy_end);
    st = ref_data_stall() || (bz && kd >= 11);
    chk({tag, ".PC_en"}, 32'(PC_en), 32'(!st));
    chk({tag, ".IF_ID_en"}, 32'(IF_ID_en), 32'(!st));
    chk({tag, ".ID_EX_reset"}, 32'(ID_EX_reset), 32'(st));
    chk({tag, ".md_busy"}, 32'(md_busy), 32'(bz));
    chk({tag, ".stall_cnt"}, stall_cnt, cnt_ref);
    if (exp_stall >= 0) begin
      chk({tag, ".dir_stall"}, 32'(ID_EX_reset), 32'(exp_stall));
      chk({tag, ".dir_pc_en"}, 32'(PC_en), 32'(exp_stall == 0));
    end
    if (exp_busy >= 0) chk({tag, ".dir_busy"}, 32'(md_busy), 32'(exp_busy));
    if (exp_cnt >= 0) chk({tag, ".dir_cnt"}, stall_cnt, 32'(exp_cnt));
    @(posedge clk);
    if (reset) begin
      busy_end = -1;
      cnt_ref = 32'd0;
    end else begin
      if (start) busy_end = cyc + md_lat_t[ke];
      if (st) cnt_ref = cnt_ref + 32'd1;
    end
    cyc++;
    #1;
  endtask

  task automatic set_ir(input logic [31:0] d, input logic [31:0] e, input logic [31:0] m);
    IR_D = d;
    IR_E = e;
    IR_M = m;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_ir(32'd0, 32'd0, 32'd0);
    step("rst", -1, -1, -1);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] lw1, addu_213, ori5, beq50, lw4, sw46, lw0, addu_200;
    reset = 1'b1;
    set_ir(32'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // state right after reset
    step("post_reset", 0, 0, 0);

    // lw $1 in EX, addu $2,$1,$3 in ID
    lw1 = i_ins(6'h23, 0, 1, 16'h0);
    addu_213 = r_ins(1, 3, 2, 6'h21);
    do_reset();
    set_ir(addu_213, lw1, 32'd0);
    step("lw_use_e", 1, 0, 0);
    set_ir(addu_213, 32'd0, lw1);
    step("lw_use_m", 0, 0, 1);

    // ori $5 in EX, beq $5,$0 in ID
    ori5 = i_ins(6'h0D, 0, 5, 16'h1);
    beq50 = i_ins(6'h04, 5, 0, 16'h4);
    do_reset();
    set_ir(beq50, ori5, 32'd0);
    step("ori_beq_e", 1, -1, 0);
    set_ir(beq50, 32'd0, ori5);
    step("ori_beq_m", 0, -1, 1);

    // lw $4 in EX, sw $4,0($6) in ID: store data not needed until MEM
    lw4 = i_ins(6'h23, 0, 4, 16'h0);
    sw46 = i_ins(6'h2B, 6, 4, 16'h0);
    do_reset();
    set_ir(sw46, lw4, 32'd0);
    step("lw_sw_e", 0, -1, 0);
    set_ir(sw46, 32'd0, lw4);
    step("lw_sw_m", 0, -1, 0);

    // register zero never creates a dependency
    lw0 = i_ins(6'h23, 0, 0, 16'h0);
    addu_200 = r_ins(0, 0, 2, 6'h21);
    set_ir(addu_200, lw0, 32'd0);
    step("zero_reg", 0, -1, 0);

`ifdef HAZARD_MDU_STALL_EN
    // div in EX, mflo waiting in ID: 11 busy/stall cycles
    do_reset();
    set_ir(r_ins(0, 0, 7, 6'h12), r_ins(1, 2, 0, 6'h1A), 32'd0);
    step("div_start", 1, 1, 0);
    IR_E = 32'd0;
    for (int i = 0; i < 10; i++) step("div_busy", 1, 1, i + 1);
    step("div_done", 0, 0, 11);

    // reset aborts a running mult
    do_reset();
    set_ir(32'd0, r_ins(1, 2, 0, 6'h18), 32'd0);
    step("mult_start", 0, 1, 0);
    IR_E = 32'd0;
    step("mult_run", 0, 1, 0);
    reset = 1'b1;
    step("mult_rst", 0, 1, 0);
    reset = 1'b0;
    step("mult_abort", 0, 0, 0);
`endif

    // randomized instruction mixes with small register numbers to provoke conflicts
    do_reset();
    for (int n = 0; n < 400; n++) begin
      IR_D = enc(int'($urandom_range(0, 18)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 16'($urandom));
      IR_E = enc(int'($urandom_range(0, 18)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 16'($urandom));
      IR_M = enc(int'($urandom_range(0, 18)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 16'($urandom));
      if ($urandom_range(0, 3) == 0) IR_E = 32'd0;
      reset = ($urandom_range(0, 49) == 0);
      step("rand", -1, -1, -1);
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all state updates on posedge clk.
- reset  in  1  synchronous, active-high reset.
- IR_D  in  32  instruction in the ID stage.
- IR_E  in  32  instruction in the EX stage, as held by the ID/EX register.
- IR_M  in  32  instruction in the MEM stage.
- PC_en  out  1  PC write enable.
- IF_ID_en  out  1  IF/ID register write enable.
- ID_EX_reset  out  1  bubble insert, driven to the ID/EX register's clear input.
- md_busy  out  1  multiply/divide unit busy.
- stall_cnt  out  32  count of stalled cycles since reset.

Function
REQ-002 The block SHALL decode this subset: addu, subu, ori, lui, lw, sw, beq, j, jal, jr, nop, mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
REQ-003 The block SHALL assign Tuse per source operand:
- beq rs/rt = 0; jr rs = 0.
- addu/subu rs/rt = 1; ori/lw/sw/mthi/mtlo/mult/multu/div/divu rs = 1; mult/multu/div/divu rt = 1.
- sw rt = 2.
REQ-004 The block SHALL assign Tnew by stage:
- In EX: addu/subu/ori/lui/mfhi/mflo = 1; lw = 2; jal = 0.
- In MEM: lw = 1; all others = 0.
REQ-005 The block SHALL select the destination register as: rd for R-type writers, rt for ori/lui/lw, 31 for jal, otherwise none.
REQ-006 data_stall SHALL be 1 when, for either stage X in {E, M} and either source s of IR_D:
- s is a used operand, and
- s != 0, and
- s equals dest(IR_X), and
- Tuse(s) < Tnew_X(IR_X).
REQ-007 The block SHALL compute stall = data_stall | md_stall, combinationally from the current inputs and state.
REQ-008 The block SHALL drive PC_en = IF_ID_en = ~stall and ID_EX_reset = stall.
REQ-009 The block SHALL define md_start = 1 when IR_E is mult, multu, div or divu.
REQ-010 On each posedge, a 4-bit counter md_cnt SHALL update with this priority:
- reset: load 0.
- else md_start: load 5 for mult/multu, 10 for div/divu.
- else md_cnt != 0: decrement by 1.
- else: hold 0.
REQ-011 md_busy SHALL equal md_start | (md_cnt != 0).
REQ-012 md_stall SHALL equal md_busy when IR_D is any of mult, multu, div, divu, mfhi, mflo, mthi, mtlo; otherwise 0.
REQ-013 When md_start and a nonzero md_cnt occur together, the block SHALL reload md_cnt; there is no queuing.
REQ-014 stall_cnt SHALL increment by 1 on each posedge where stall = 1 and reset = 0, wrapping from 0xFFFFFFFF to 0.
REQ-015 A stall SHALL persist exactly as long as its condition holds; the block has no minimum or extra stall cycles.

Reset
REQ-016 While reset = 1 at a posedge, the block SHALL set md_cnt = 0 and stall_cnt = 0.
REQ-017 In the cycle after reset, with IR_D = IR_E = IR_M = 0, the block SHALL drive PC_en = 1, IF_ID_en = 1, ID_EX_reset = 0, md_busy = 0.
REQ-018 A reset during an MDU operation SHALL abort that operation, and md_busy SHALL read 0 in the next cycle unless IR_E is a multiply/divide.

Configuration
REQ-019 With macro HAZARD_MDU_STALL_EN defined, the block SHALL implement REQ-009 to REQ-013.
REQ-020 With HAZARD_MDU_STALL_EN undefined:
- md_cnt SHALL be absent.
- md_busy and md_stall SHALL be constant 0.
- The multiply/divide and HI/LO opcodes SHALL decode as no-hazard.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- lw $1 in EX, addu $2,$1,$3 in ID -> one cycle with stall=1 and ID_EX_reset=1; next cycle (lw in MEM, Tnew 1 vs Tuse 1) -> stall=0; stall_cnt=1.
- ori $5 in EX, beq $5,$0 in ID -> stall=1 for 1 cycle; then ori in MEM -> stall=0.
- lw $4 in EX, sw $4,0($6) in ID -> stall=0 throughout (Tuse 2 vs Tnew 2).
- lw $0 in EX, addu $2,$0,$0 in ID -> stall=0 (register-zero exemption).
- [HAZARD_MDU_STALL_EN] div in EX, followed by mflo in ID -> md_busy=1 for 11 cycles (start cycle + 10), stall=1 throughout, then stall=0; stall_cnt=11.
- [HAZARD_MDU_STALL_EN] mult in EX, then reset asserted two cycles later -> md_busy=0 and stall_cnt=0 on the next cycle with IR_E=0.
